// File: rtl/gps_nmea_framer.sv
// rtl/gps_nmea_framer.sv - NMEA-0183 sentence framer with checksum check and line buffer
`timescale 1ns/1ps
module gps_nmea_framer #(
  parameter int MAX_LEN = 80,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              sentence_ready,
  output logic [ADDR_W-1:0] sentence_len,
  input  logic              ack,
  output logic [15:0]       cksum_err_cnt,
  output logic [15:0]       frame_err_cnt,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_BODY, S_CK_HI, S_CK_LO, S_WAIT_CR, S_WAIT_LF, S_COMMIT
  } state_t;

  localparam logic [7:0]      CH_DOLLAR = 8'h24;
  localparam logic [7:0]      CH_STAR   = 8'h2A;
  localparam logic [7:0]      CH_CR     = 8'h0D;
  localparam logic [7:0]      CH_LF     = 8'h0A;
  localparam logic [ADDR_W:0] LP_MAX    = MAX_LEN[ADDR_W:0];

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_xor;
  logic [ADDR_W:0]   r_ptr;
  logic [3:0]        r_ck_hi, r_ck_lo;
  logic              r_we;
  logic              r_ready;
  logic [ADDR_W-1:0] r_len;
  logic [7:0]        r_rd_data;
  logic [15:0]       r_ck_cnt, r_fr_cnt, r_dr_cnt;
  logic [7:0]        r_mem [0:(2**ADDR_W)-1];

  logic       w_start, w_body, w_lat_hi, w_lat_lo, w_frame_err;
  logic       w_commit, w_match;
  logic [4:0] w_hex;

  // Returns {valid, nibble} for an ASCII hex digit in either case.
  function automatic logic [4:0] hex_val(input logic [7:0] c);
    logic [7:0] t;
    t = 8'h00;
    if (c >= 8'h30 && c <= 8'h39)      t = c - 8'h30;
    else if (c >= 8'h41 && c <= 8'h46) t = c - 8'h37;
    else if (c >= 8'h61 && c <= 8'h66) t = c - 8'h57;
    else                               return 5'b0_0000;
    return {1'b1, t[3:0]};
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_body      = 1'b0;
    w_lat_hi    = 1'b0;
    w_lat_lo    = 1'b0;
    w_frame_err = 1'b0;
    w_commit    = (r_state == S_COMMIT);
    w_match     = ({r_ck_hi, r_ck_lo} == r_xor);
    w_hex       = hex_val(rx_data);
    if (r_state == S_COMMIT) begin
      w_state_nxt = S_IDLE;
    end else if (rx_valid) begin
      if (rx_data == CH_DOLLAR) begin
        w_start     = 1'b1;
        w_state_nxt = S_BODY;
      end else begin
        case (r_state)
          S_BODY: begin
            if (rx_data == CH_STAR) begin
              w_state_nxt = S_CK_HI;
            end else if (r_ptr == LP_MAX) begin
              w_frame_err = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_body = 1'b1;
            end
          end
          S_CK_HI: begin
            w_lat_hi    = w_hex[4];
            w_frame_err = !w_hex[4];
            w_state_nxt = w_hex[4] ? S_CK_LO : S_IDLE;
          end
          S_CK_LO: begin
            w_lat_lo    = w_hex[4];
            w_frame_err = !w_hex[4];
            w_state_nxt = w_hex[4] ? S_WAIT_CR : S_IDLE;
          end
          S_WAIT_CR: begin
            w_frame_err = (rx_data != CH_CR);
            w_state_nxt = (rx_data == CH_CR) ? S_WAIT_LF : S_IDLE;
          end
          S_WAIT_LF: begin
            w_frame_err = (rx_data != CH_LF);
            w_state_nxt = (rx_data == CH_LF) ? S_COMMIT : S_IDLE;
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_xor     <= 8'h00;
      r_ptr     <= '0;
      r_ck_hi   <= 4'h0;
      r_ck_lo   <= 4'h0;
      r_we      <= 1'b0;
      r_ready   <= 1'b0;
      r_len     <= '0;
      r_rd_data <= 8'h00;
      r_ck_cnt  <= 16'h0000;
      r_fr_cnt  <= 16'h0000;
      r_dr_cnt  <= 16'h0000;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_data <= r_mem[rd_addr];
      if (w_start) begin
        r_xor <= 8'h00;
        r_ptr <= '0;
        r_we  <= !r_ready;
      end
      if (w_body) begin
        r_xor <= r_xor ^ rx_data;
        r_ptr <= r_ptr + (ADDR_W+1)'(1);
      end
      if (w_lat_hi) r_ck_hi <= w_hex[3:0];
      if (w_lat_lo) r_ck_lo <= w_hex[3:0];
      // A successful commit implies ready was low at '$', so it never races ack.
      if (ack) r_ready <= 1'b0;
      if (w_commit && w_match && r_we) begin
        r_ready <= 1'b1;
        r_len   <= r_ptr[ADDR_W-1:0];
      end
      if (w_commit && !w_match && r_ck_cnt != 16'hFFFF) r_ck_cnt <= r_ck_cnt + 16'd1;
      if (w_commit && w_match && !r_we && r_dr_cnt != 16'hFFFF) r_dr_cnt <= r_dr_cnt + 16'd1;
      if (w_frame_err && r_fr_cnt != 16'hFFFF) r_fr_cnt <= r_fr_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_body && r_we) r_mem[r_ptr[ADDR_W-1:0]] <= rx_data;
  end

  assign rd_data        = r_rd_data;
  assign sentence_ready = r_ready;
  assign sentence_len   = r_len;
  assign cksum_err_cnt  = r_ck_cnt;
  assign frame_err_cnt  = r_fr_cnt;
  assign drop_cnt       = r_dr_cnt;

endmodule

// File: doc/gps_nmea_framer.md
Name: gps_nmea_framer

Overview:
- Sequences the GPS serial receive path: consumes bytes from the GPS UART receiver and frames NMEA-0183 sentences ($...*hh CR LF).
- Verifies the XOR checksum and stores each valid sentence body in a line buffer.
- Hands the buffer to the HPS-side reader with a ready/ack handshake.
- Keeps saturating error and drop counters so software can monitor link health.

Parameters:
- MAX_LEN, 80: maximum body length in bytes, counting the characters between '$' and '*' exclusive.
- ADDR_W, 7: buffer address width; must satisfy 2^ADDR_W >= MAX_LEN.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from the UART receiver
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- rd_addr  in  ADDR_W  line-buffer read address
- rd_data  out  8  buffered byte; registered, one-cycle latency
- sentence_ready  out  1  a valid sentence is held in the buffer
- sentence_len  out  ADDR_W  body length of the held sentence
- ack  in  1  one-cycle pulse; releases the buffer
- cksum_err_cnt  out  16  count of checksum mismatches
- frame_err_cnt  out  16  count of overlength, bad-hex or missing CR/LF events
- drop_cnt  out  16  count of valid sentences lost because the buffer was busy

Behaviour:
- Reset values: sentence_ready=0, sentence_len=0, rd_data=0, all counters=0, FSM=IDLE. Buffer contents are undefined.
- FSM acts only on cycles with rx_valid=1. Decoding happens in the same cycle the strobe arrives.
  - IDLE: '$' -> BODY; clear the XOR accumulator and write pointer. All other bytes are ignored.
  - BODY: '*' -> CK_HI. Any other byte: XOR it into the accumulator, write it at the pointer if writes are enabled, increment the pointer. If the byte would make length > MAX_LEN: frame_err_cnt++, go to IDLE.
  - CK_HI / CK_LO: accept '0'-'9', 'A'-'F', 'a'-'f' and latch the nibble. A non-hex byte: frame_err_cnt++, go to IDLE.
  - WAIT_CR: requires 0x0D, then -> WAIT_LF.
  - WAIT_LF: requires 0x0A, then -> COMMIT. Any other byte in WAIT_CR or WAIT_LF: frame_err_cnt++, go to IDLE.
  - COMMIT: internal single cycle, no rx_valid needed, always returns to IDLE.
    - Checksum mismatch: cksum_err_cnt++.
    - Match with writes enabled: sentence_ready=1 and sentence_len=pointer, both on the next edge.
    - Match with writes disabled: drop_cnt++.
- '$' seen in any state other than IDLE resynchronises: restart BODY, no counter change.
- Write enable is sampled at '$' and equals !sentence_ready. It is held for the whole sentence, so a held buffer is never corrupted.
- ack=1 clears sentence_ready on the next edge.
  - If ack and COMMIT fall in the same cycle, ack still clears ready.
  - The committed sentence lands only if its writes were enabled, which cannot be true while ready was 1, so no conflict arises.
  - ack while sentence_ready=0 is ignored.
- Empty body ("$*00\r\n") is valid: sentence_len=0, sentence_ready=1.
- An rx_valid byte arriving during COMMIT is processed in IDLE on the following strobe only. The UART byte rate guarantees at least 2 idle cycles between strobes, so none is lost.
- Counters saturate at 16'hFFFF and never wrap.
- Read port is an inferred synchronous RAM: rd_data = mem[rd_addr] registered one cycle after rd_addr is presented. Reading is legal at any time; contents are stable while sentence_ready=1.
- Reset asserted mid-sentence: the FSM returns to IDLE immediately and the partial sentence is discarded without counting.

Test Plan:
- Stream "$AB*03\r\n" -> sentence_ready=1 two clocks after the LF strobe; sentence_len=2; rd_addr 0,1 read 0x41,0x42; all counters 0.
- Stream "$AB*04\r\n" -> sentence_ready stays 0; cksum_err_cnt=1.
- Send "$AB*03\r\n", do not ack, then send "$A*41\r\n" -> drop_cnt=1; buffer still holds "AB" with len 2. Pulse ack, resend "$A*41\r\n" -> ready=1, len=1, rd[0]=0x41.
- Cases:
  - Send "$" followed by 81 body bytes -> frame_err_cnt=1, FSM returns to IDLE.
  - Send "$AB*0G" -> frame_err_cnt=2.
  - Send "$AB*03\rX" -> frame_err_cnt=3.
- Send "$XY$AB*03\r\n" -> resync; len=2, data "AB", no errors. Then "$*00\r\n" after ack -> ready=1, len=0.
- Assert reset_n=0 mid-BODY -> all outputs return to reset values asynchronously; a following "$AB*03\r\n" frames normally.
